web1_lp_seq: RTL and testbench

Low-power entry/exit sequencer that sits directly downstream of the web1 wake-event block. It consumes `wake`, `activate_low_pwr` and `epu_enable`, then runs the isolation, clock-gate and power-request sequence against the PMU. It returns a `clear_function` pulse that retires the serviced low-power event in web1. All outputs are registered, and all sequencing is in one clock domain.

---
 rtl/web1_lp_seq_pkg.sv | 26 ++
 rtl/web1_lp_seq_if.sv | 35 +++
 rtl/web1_lp_settle_cnt.sv | 25 ++
 rtl/web1_lp_seq.sv | 110 +++++++++++
 tb/tb_web1_lp_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/web1_lp_seq_pkg.sv
// Shared types and default timing constants for the web1 low-power sequencer.
// Optional ack watchdog is enabled with WEB1_LP_SEQ_TIMEOUT_EN.
package web1_lp_seq_pkg;

   typedef enum logic [3:0] {
      ST_ACTIVE  = 4'd0,
      ST_ISO_ON  = 4'd1,
      ST_CLK_OFF = 4'd2,
      ST_PWR_DN  = 4'd3,
      ST_SLEEP   = 4'd4,
      ST_PWR_UP  = 4'd5,
      ST_CLK_ON  = 4'd6,
      ST_ISO_OFF = 4'd7,
      ST_CLEAR   = 4'd8
   } web1_lp_state_e;

   localparam int unsigned ISO_DLY_DEF  = 4;
   localparam int unsigned CLK_DLY_DEF  = 2;
   localparam int unsigned CNT_W_DEF    = 8;
   localparam int unsigned CLR_HOLD_DEF = 4;

   // Watchdog loads 4094 so the timeout fires on the 4095th cycle in the state.
   localparam int unsigned  WDOG_W    = 12;
   localparam logic [11:0]  WDOG_LOAD = 12'd4094;

endpackage

// File: rtl/web1_lp_seq_if.sv
// Sequencer-to-web1/PMU signal bundle; master is the sequencer side.
// pmu_timeout exists only with WEB1_LP_SEQ_TIMEOUT_EN.
interface web1_lp_seq_if;

   logic       wake;
   logic       activate_low_pwr;
   logic       epu_enable;
   logic       pmu_pwr_ack;
   logic       pmu_pwr_req;
   logic       iso_en;
   logic       clk_gate_en;
   logic       clear_function;
   logic       lp_active;
   logic [3:0] lp_state;
`ifdef WEB1_LP_SEQ_TIMEOUT_EN
   logic       pmu_timeout;
`endif

   modport master (
`ifdef WEB1_LP_SEQ_TIMEOUT_EN
      output pmu_timeout,
`endif
      input  wake, activate_low_pwr, epu_enable, pmu_pwr_ack,
      output pmu_pwr_req, iso_en, clk_gate_en, clear_function, lp_active, lp_state
   );

   modport slave (
`ifdef WEB1_LP_SEQ_TIMEOUT_EN
      input  pmu_timeout,
`endif
      output wake, activate_low_pwr, epu_enable, pmu_pwr_ack,
      input  pmu_pwr_req, iso_en, clk_gate_en, clear_function, lp_active, lp_state
   );

endinterface

// File: rtl/web1_lp_settle_cnt.sv
// Loadable saturating down-counter; zero is high while the count reads 0.
module web1_lp_settle_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clkclk,
   input  logic         sysreset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clkclk) begin
      if (sysreset)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/web1_lp_seq.sv
// Low-power entry/exit sequencer: isolation, clock gate, PMU power handshake, event clear.
// WEB1_LP_SEQ_TIMEOUT_EN adds a 12-bit ack watchdog and sticky pmu_timeout.
module web1_lp_seq
   import web1_lp_seq_pkg::*;
#(
   parameter int unsigned ISO_DLY  = ISO_DLY_DEF,
   parameter int unsigned CLK_DLY  = CLK_DLY_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned CLR_HOLD = CLR_HOLD_DEF
) (
   input  logic          clkclk,
   input  logic          sysreset,
   web1_lp_seq_if.master bus
);

   web1_lp_state_e state, next_state;
   logic             cnt_load, cnt_zero, timeout_hit;
   logic [CNT_W-1:0] cnt_value;
   logic             req_q, iso_q, gate_q, clr_q, act_q;

   always_comb begin
      next_state = state;
      case (state)
         ST_ACTIVE:  if (bus.activate_low_pwr && bus.epu_enable && !bus.wake) next_state = ST_ISO_ON;
         ST_ISO_ON:  if (bus.wake) next_state = ST_ISO_OFF;
                     else if (cnt_zero) next_state = ST_CLK_OFF;
         ST_CLK_OFF: if (bus.wake) next_state = ST_CLK_ON;
                     else if (cnt_zero) next_state = ST_PWR_DN;
         ST_PWR_DN:  if (bus.pmu_pwr_ack) next_state = ST_SLEEP;
                     else if (timeout_hit) next_state = ST_PWR_UP;
         ST_SLEEP:   if (bus.wake) next_state = ST_PWR_UP;
         ST_PWR_UP:  if (!bus.pmu_pwr_ack || timeout_hit) next_state = ST_CLK_ON;
         ST_CLK_ON:  if (cnt_zero) next_state = ST_ISO_OFF;
         ST_ISO_OFF: if (cnt_zero) next_state = ST_CLEAR;
         ST_CLEAR:   if (cnt_zero) next_state = ST_ACTIVE;
         default:    next_state = ST_ACTIVE;
      endcase
   end

   // Delay is loaded as DLY-1 on entry so the state lasts exactly DLY cycles.
   always_comb begin
      cnt_load  = (next_state != state);
      cnt_value = '0;
      case (next_state)
         ST_ISO_ON, ST_ISO_OFF: cnt_value = CNT_W'(ISO_DLY - 1);
         ST_CLK_OFF, ST_CLK_ON: cnt_value = CNT_W'(CLK_DLY - 1);
         ST_CLEAR:              cnt_value = CNT_W'(CLR_HOLD - 1);
         default:               cnt_value = '0;
      endcase
   end

   web1_lp_settle_cnt #(.W(CNT_W)) u_settle (
      .clkclk   (clkclk),
      .sysreset (sysreset),
      .load     (cnt_load),
      .value    (cnt_value),
      .zero     (cnt_zero)
   );

`ifdef WEB1_LP_SEQ_TIMEOUT_EN
   logic wd_zero, timeout_q;

   web1_lp_settle_cnt #(.W(WDOG_W)) u_wdog (
      .clkclk   (clkclk),
      .sysreset (sysreset),
      .load     (cnt_load),
      .value    (WDOG_LOAD),
      .zero     (wd_zero)
   );

   assign timeout_hit = wd_zero && ((state == ST_PWR_DN && !bus.pmu_pwr_ack) ||
                                    (state == ST_PWR_UP &&  bus.pmu_pwr_ack));

   always_ff @(posedge clkclk) begin
      if (sysreset) timeout_q <= 1'b0;
      else          timeout_q <= timeout_q | timeout_hit;
   end

   assign bus.pmu_timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
`endif

   // Outputs are registered from next_state so they change with the state register.
   always_ff @(posedge clkclk) begin
      if (sysreset) begin
         state  <= ST_ACTIVE;
         req_q  <= 1'b0;
         iso_q  <= 1'b0;
         gate_q <= 1'b0;
         clr_q  <= 1'b0;
         act_q  <= 1'b0;
      end else begin
         state  <= next_state;
         req_q  <= next_state inside {ST_PWR_DN, ST_SLEEP};
         iso_q  <= next_state inside {ST_ISO_ON, ST_CLK_OFF, ST_PWR_DN, ST_SLEEP, ST_PWR_UP, ST_CLK_ON};
         gate_q <= next_state inside {ST_CLK_OFF, ST_PWR_DN, ST_SLEEP, ST_PWR_UP};
         clr_q  <= (next_state == ST_CLEAR);
         act_q  <= (next_state != ST_ACTIVE);
      end
   end

   assign bus.pmu_pwr_req    = req_q;
   assign bus.iso_en         = iso_q;
   assign bus.clk_gate_en    = gate_q;
   assign bus.clear_function = clr_q;
   assign bus.lp_active      = act_q;
   assign bus.lp_state       = state;

endmodule

// File: tb/tb_web1_lp_seq.sv
// Scoreboard bench: scenario tasks push expected output transitions; a monitor pops on every output change.
module tb_web1_lp_seq;
   import web1_lp_seq_pkg::*;

   localparam int I = 4;
   localparam int C = 2;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   web1_lp_seq_if bus();

   web1_lp_seq #(.ISO_DLY(I), .CLK_DLY(C), .CNT_W(8), .CLR_HOLD(H)) dut (
      .clkclk   (clk),
      .sysreset (rst),
      .bus      (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [8:0] v;
   } ev_t;
   ev_t expq[$];

   // Expected output vector for a state: {req, iso, gate, clear, lp_active, lp_state}.
   function automatic logic [8:0] outs_of(input web1_lp_state_e s);
      logic req, iso, gate, clr;
      req  = (s == ST_PWR_DN) || (s == ST_SLEEP);
      gate = (s == ST_CLK_OFF) || (s == ST_PWR_DN) || (s == ST_SLEEP) || (s == ST_PWR_UP);
      iso  = gate || (s == ST_ISO_ON) || (s == ST_CLK_ON);
      clr  = (s == ST_CLEAR);
      return {req, iso, gate, clr, (s != ST_ACTIVE), 4'(s)};
   endfunction

   function automatic logic [8:0] cur();
      return {bus.pmu_pwr_req, bus.iso_en, bus.clk_gate_en, bus.clear_function,
              bus.lp_active, bus.lp_state};
   endfunction

   task automatic push(input int c, input web1_lp_state_e s);
      expq.push_back('{c, outs_of(s)});
   endtask

   bit         mon_en = 1'b0;
   logic [8:0] prev;

   always @(negedge clk) begin
      logic [8:0] v;
      ev_t e;
      if (mon_en) begin
         v = cur();
         if (v !== prev) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, v);
            end else begin
               e = expq.pop_front();
               if (e.cyc != cyc || e.v !== v) begin
                  failures++;
                  $display("FAIL transition cyc=%0d got=%b required cyc=%0d vec=%b", cyc, v, e.cyc, e.v);
               end
            end
            prev = v;
         end
      end
   end

   task automatic at(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tail(input int k);
      push(k + C, ST_ISO_OFF);
      push(k + C + I, ST_CLEAR);
      push(k + C + I + H, ST_ACTIVE);
      at(k + C + I + H);
   endtask

   task automatic start(input int n);
      at(n);
      bus.activate_low_pwr = 1'b1;
      bus.epu_enable       = 1'b1;
      push(n + 1, ST_ISO_ON);
   endtask

   // Full entry/exit; rx >= 0 applies a one-cycle reset rx cycles into SLEEP instead of waking.
   task automatic run_full(input int n, input int a, input int w, input int b,
                           input bit drop_epu, input bit wake_dn, input int rx);
      int p1, p2, s, u, k;
      start(n);
      p1 = n + 1 + I;
      p2 = p1 + C;
      push(p1, ST_CLK_OFF);
      push(p2, ST_PWR_DN);
      at(n + 1);
      bus.activate_low_pwr = 1'b0;
      if (drop_epu) bus.epu_enable = 1'b0;
      at(p2);
      if (wake_dn) bus.wake = 1'b1;
      at(p2 + 1);
      bus.wake = 1'b0;
      at(p2 + a);
      bus.pmu_pwr_ack = 1'b1;
      s = p2 + a + 1;
      push(s, ST_SLEEP);
      if (rx >= 0) begin
         at(s + rx);
         rst = 1'b1;
         bus.pmu_pwr_ack = 1'b0;
         push(s + rx + 1, ST_ACTIVE);
         at(s + rx + 1);
         rst = 1'b0;
         return;
      end
      at(s + w);
      bus.wake = 1'b1;
      u = s + w + 1;
      push(u, ST_PWR_UP);
      at(u);
      bus.wake = 1'b0;
      at(u + b);
      bus.pmu_pwr_ack = 1'b0;
      k = u + b + 1;
      push(k, ST_CLK_ON);
      tail(k);
   endtask

   task automatic run_abort_iso(input int n, input int j);
      start(n);
      at(n + 1);
      bus.activate_low_pwr = 1'b0;
      at(n + 1 + j);
      bus.wake = 1'b1;
      push(n + 2 + j, ST_ISO_OFF);
      push(n + 2 + j + I, ST_CLEAR);
      push(n + 2 + j + I + H, ST_ACTIVE);
      at(n + 2 + j);
      bus.wake = 1'b0;
      at(n + 2 + j + I + H);
   endtask

   task automatic run_abort_clk(input int n, input int j);
      int p1, k;
      start(n);
      p1 = n + 1 + I;
      push(p1, ST_CLK_OFF);
      at(n + 1);
      bus.activate_low_pwr = 1'b0;
      at(p1 + j);
      bus.wake = 1'b1;
      k = p1 + j + 1;
      push(k, ST_CLK_ON);
      at(k);
      bus.wake = 1'b0;
      tail(k);
   endtask

   task automatic run_same_cycle(input int n);
      at(n);
      bus.activate_low_pwr = 1'b1;
      bus.epu_enable       = 1'b1;
      bus.wake             = 1'b1;
      at(n + 1);
      bus.activate_low_pwr = 1'b0;
      bus.wake             = 1'b0;
      at(n + 2);
      checks++;
      if (bus.lp_state !== 4'(ST_ACTIVE)) begin
         failures++;
         $display("FAIL same_cycle_state got=%0d required=%0d", bus.lp_state, 4'(ST_ACTIVE));
      end
   endtask

   task automatic run_epu_hold(input int n);
      at(n);
      bus.activate_low_pwr = 1'b1;
      bus.epu_enable       = 1'b0;
      run_full(n + 100, 1, 2, 1, 1'b0, 1'b0, -1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout cyc=%0d required=finish", cyc);
      $fatal(1, "bench did not terminate");
   end

   initial begin
      bus.wake = 1'b0;
      bus.activate_low_pwr = 1'b0;
      bus.epu_enable = 1'b0;
      bus.pmu_pwr_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (cur() !== 9'd0) begin
         failures++;
         $display("FAIL reset_state got=%b required=%b", cur(), 9'd0);
      end
      prev = cur();
      mon_en = 1'b1;

      run_full(10, 3, 9, 2, 1'b0, 1'b0, -1);
      run_same_cycle(cyc + 3);
      run_abort_clk(cyc + 3, 1);
      run_epu_hold(cyc + 2);
      run_full(cyc + 2, 2, 0, 0, 1'b0, 1'b0, 3);

      for (int it = 0; it < 20; it++) begin
         int kind, n;
         n = cyc + int'($urandom_range(1, 4));
         kind = int'($urandom_range(0, 4));
         case (kind)
            0, 1: run_full(n, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                           int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), -1);
            2:    run_abort_iso(n, int'($urandom_range(0, I - 1)));
            3:    run_abort_clk(n, int'($urandom_range(0, C - 1)));
            default: run_same_cycle(n);
         endcase
      end

`ifdef WEB1_LP_SEQ_TIMEOUT_EN
      begin
         int n, p2, k;
         n = cyc + 2;
         start(n);
         p2 = n + 1 + I + C;
         push(n + 1 + I, ST_CLK_OFF);
         push(p2, ST_PWR_DN);
         push(p2 + 4095, ST_PWR_UP);
         k = p2 + 4096;
         push(k, ST_CLK_ON);
         at(n + 1);
         bus.activate_low_pwr = 1'b0;
         at(p2 + 4094);
         checks++;
         if (bus.pmu_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got=%b required=0", bus.pmu_timeout);
         end
         at(p2 + 4095);
         checks++;
         if (bus.pmu_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set got=%b required=1", bus.pmu_timeout);
         end
         tail(k);
         checks++;
         if (bus.pmu_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b required=1", bus.pmu_timeout);
         end
      end
`endif

      at(cyc + 3);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL pending_events got=%0d required=0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
